// File: rtl/controle_busca_pc16.sv
// controle_busca_pc16 -- fetch sequencer for the 16-bit program counter.
//
// Drives the load port of the external PC register, runs a req/ready read
// handshake towards instruction memory, buffers the fetched word and offers it
// to the decoder via a valid/accept handshake. Branch redirects take priority
// over both memory completion and decoder acceptance.
//
// Ports:
//   clock_sinal      in   1     system clock, rising edge
//   reset_sinal      in   1     synchronous active-high reset
//   habilita         in   1     allows new fetches to start
//   desvio_valido    in   1     redirect request
//   desvio_endereco  in   LARG  redirect target
//   pc_atual         in   LARG  current PC (external register output)
//   pc_carrega       out  1     PC register load enable
//   pc_proximo       out  LARG  value to load into the PC register
//   mem_req          out  1     memory read request
//   mem_endereco     out  LARG  read address (pc_atual)
//   mem_pronto       in   1     read data valid this cycle
//   mem_dado         in   LARG  read data
//   instr_valida     out  1     fetched instruction available
//   instr_saida      out  LARG  fetched instruction buffer
//   instr_aceita     in   1     decoder takes instr_saida this cycle

module controle_busca_pc16 #(
  parameter int unsigned         LARG        = 16,
  parameter logic [LARG-1:0]     INCREMENTO  = LARG'(1),
  parameter logic [LARG-1:0]     END_INICIAL = '0
) (
  input  logic            clock_sinal,
  input  logic            reset_sinal,
  input  logic            habilita,
  input  logic            desvio_valido,
  input  logic [LARG-1:0] desvio_endereco,
  input  logic [LARG-1:0] pc_atual,
  output logic            pc_carrega,
  output logic [LARG-1:0] pc_proximo,
  output logic            mem_req,
  output logic [LARG-1:0] mem_endereco,
  input  logic            mem_pronto,
  input  logic [LARG-1:0] mem_dado,
  output logic            instr_valida,
  output logic [LARG-1:0] instr_saida,
  input  logic            instr_aceita
);

  typedef enum logic [1:0] {
    INICIA  = 2'b00,
    OCIOSO  = 2'b01,
    BUSCA   = 2'b10,
    ENTREGA = 2'b11
  } estado_t;

  estado_t estado;
  estado_t estado_prox;
  logic    captura;

  // The PC register is the address source, so the request address needs no
  // local copy: it stays stable because the PC only loads on completion.
  assign mem_endereco = pc_atual;

  always_comb begin
    estado_prox  = estado;
    pc_carrega   = 1'b0;
    pc_proximo   = pc_atual;
    mem_req      = 1'b0;
    instr_valida = 1'b0;
    captura      = 1'b0;

    case (estado)
      INICIA: begin
        pc_carrega  = 1'b1;
        pc_proximo  = END_INICIAL;
        estado_prox = OCIOSO;
      end

      OCIOSO: begin
        if (desvio_valido) begin
          pc_carrega = 1'b1;
          pc_proximo = desvio_endereco;
        end else if (habilita) begin
          estado_prox = BUSCA;
        end
      end

      BUSCA: begin
        mem_req = 1'b1;
        // Redirect wins over completion: the returning word is dropped.
        if (desvio_valido) begin
          pc_carrega  = 1'b1;
          pc_proximo  = desvio_endereco;
          estado_prox = OCIOSO;
        end else if (mem_pronto) begin
          captura     = 1'b1;
          pc_carrega  = 1'b1;
          pc_proximo  = pc_atual + INCREMENTO;
          estado_prox = ENTREGA;
        end
      end

      ENTREGA: begin
        instr_valida = 1'b1;
        // Redirect wins over accept: the buffered word is never delivered.
        if (desvio_valido) begin
          pc_carrega  = 1'b1;
          pc_proximo  = desvio_endereco;
          estado_prox = OCIOSO;
        end else if (instr_aceita) begin
          estado_prox = habilita ? BUSCA : OCIOSO;
        end
      end

      default: estado_prox = INICIA;
    endcase

    // Reset overrides whatever the current state would present.
    if (reset_sinal) begin
      mem_req      = 1'b0;
      instr_valida = 1'b0;
      pc_carrega   = 1'b0;
      pc_proximo   = pc_atual;
      captura      = 1'b0;
    end
  end

  always_ff @(posedge clock_sinal) begin
    if (reset_sinal) begin
      estado      <= INICIA;
      instr_saida <= '0;
    end else begin
      estado <= estado_prox;
      if (captura) begin
        instr_saida <= mem_dado;
      end
    end
  end

endmodule

// File: tb/tb_controle_busca_pc16.sv
module tb_controle_busca_pc16;

  logic        clk = 1'b0;
  logic        rst;
  logic        hab;
  logic        desv;
  logic [15:0] desv_end;
  logic        pronto;
  logic        aceita;
  logic        pc_carrega;
  logic [15:0] pc_proximo;
  logic        mem_req;
  logic [15:0] mem_endereco;
  logic [15:0] mem_dado;
  logic        instr_valida;
  logic [15:0] instr_saida;

  // PC register model; starts with a junk value so the initial load shows.
  logic [15:0] pc = 16'hAAAA;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pc_carrega) pc <= pc_proximo;
  end

  // Memory model: data is the bitwise complement of the address.
  assign mem_dado = ~mem_endereco;

  controle_busca_pc16 #(
    .LARG        (16),
    .INCREMENTO  (16'h0001),
    .END_INICIAL (16'h0000)
  ) dut (
    .clock_sinal     (clk),
    .reset_sinal     (rst),
    .habilita        (hab),
    .desvio_valido   (desv),
    .desvio_endereco (desv_end),
    .pc_atual        (pc),
    .pc_carrega      (pc_carrega),
    .pc_proximo      (pc_proximo),
    .mem_req         (mem_req),
    .mem_endereco    (mem_endereco),
    .mem_pronto      (pronto),
    .mem_dado        (mem_dado),
    .instr_valida    (instr_valida),
    .instr_saida     (instr_saida),
    .instr_aceita    (aceita)
  );

  typedef struct {
    logic        rst;
    logic        hab;
    logic        desv;
    logic [15:0] dend;
    logic        pronto;
    logic        aceita;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_val;
    logic [15:0] e_saida;
    logic        e_car;
    logic [15:0] e_prox;
  } vec_t;

  vec_t tab[16];

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic h, input logic d, input logic [15:0] de,
                       input logic p, input logic a);
    rst = r; hab = h; desv = d; desv_end = de; pronto = p; aceita = a;
  endtask

  // Checks combinational/registered outputs 2 time units after the inputs
  // were driven, then advances to 1 unit past the next rising edge.
  task automatic expect_cyc(input string nm, input logic req, input logic [15:0] addr,
                            input logic val, input logic [15:0] saida,
                            input logic car, input logic [15:0] prox);
    #2;
    chk({nm, ".mem_req"}, {15'd0, mem_req}, {15'd0, req});
    if (req) chk({nm, ".mem_endereco"}, mem_endereco, addr);
    chk({nm, ".instr_valida"}, {15'd0, instr_valida}, {15'd0, val});
    chk({nm, ".instr_saida"}, instr_saida, saida);
    chk({nm, ".pc_carrega"}, {15'd0, pc_carrega}, {15'd0, car});
    chk({nm, ".pc_proximo"}, pc_proximo, prox);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rst hab desv dend pronto aceita | req addr val saida car prox
    // Streaming fetch from reset release (1 word / 2 cycles)
    tab[0]  = '{0,1,0,16'h0000,1,1, 0,16'h0000,0,16'h0000,1,16'h0000}; // INICIA
    tab[1]  = '{0,1,0,16'h0000,1,1, 0,16'h0000,0,16'h0000,0,16'h0000}; // OCIOSO
    tab[2]  = '{0,1,0,16'h0000,1,1, 1,16'h0000,0,16'h0000,1,16'h0001};
    tab[3]  = '{0,1,0,16'h0000,1,1, 0,16'h0000,1,16'hFFFF,0,16'h0001};
    tab[4]  = '{0,1,0,16'h0000,1,1, 1,16'h0001,0,16'hFFFF,1,16'h0002};
    tab[5]  = '{0,1,0,16'h0000,1,1, 0,16'h0000,1,16'hFFFE,0,16'h0002};
    tab[6]  = '{0,1,0,16'h0000,1,1, 1,16'h0002,0,16'hFFFE,1,16'h0003};
    tab[7]  = '{0,1,0,16'h0000,1,1, 0,16'h0000,1,16'hFFFD,0,16'h0003};
    // Reset pulsed while in BUSCA, then INICIA ignores a redirect
    tab[8]  = '{1,1,0,16'h0000,1,1, 0,16'h0000,0,16'hFFFD,0,16'h0003};
    tab[9]  = '{0,1,1,16'h5555,0,0, 0,16'h0000,0,16'h0000,1,16'h0000};
    // Three memory wait cycles, address held at 0000
    tab[10] = '{0,1,0,16'h0000,0,0, 0,16'h0000,0,16'h0000,0,16'h0000};
    tab[11] = '{0,1,0,16'h0000,0,0, 1,16'h0000,0,16'h0000,0,16'h0000};
    tab[12] = '{0,1,0,16'h0000,0,0, 1,16'h0000,0,16'h0000,0,16'h0000};
    tab[13] = '{0,1,0,16'h0000,0,0, 1,16'h0000,0,16'h0000,0,16'h0000};
    tab[14] = '{0,1,0,16'h0000,1,0, 1,16'h0000,0,16'h0000,1,16'h0001};
    tab[15] = '{0,1,0,16'h0000,1,0, 0,16'h0000,1,16'hFFFF,0,16'h0001};

    drive(1, 0, 0, 16'h0000, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    #2;
    chk("reset.mem_req", {15'd0, mem_req}, 16'd0);
    chk("reset.instr_valida", {15'd0, instr_valida}, 16'd0);
    chk("reset.instr_saida", instr_saida, 16'h0000);

    for (int i = 0; i < 16; i++) begin
      drive(tab[i].rst, tab[i].hab, tab[i].desv, tab[i].dend, tab[i].pronto, tab[i].aceita);
      expect_cyc($sformatf("vec%0d", i), tab[i].e_req, tab[i].e_addr, tab[i].e_val,
                 tab[i].e_saida, tab[i].e_car, tab[i].e_prox);
      if (i == 9) chk("reinit.pc", pc, 16'h0000);
    end

    // Backpressure: four more cycles without accept (five in total), PC frozen
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 0, 16'h0000, 1, 0);
      expect_cyc("stall", 0, 16'h0000, 1, 16'hFFFF, 0, 16'h0001);
      chk("stall.pc", pc, 16'h0001);
    end
    drive(0, 1, 0, 16'h0000, 1, 1);
    expect_cyc("accept", 0, 16'h0000, 1, 16'hFFFF, 0, 16'h0001);

    // Redirect in the same BUSCA cycle as mem_pronto: word dropped
    drive(0, 1, 1, 16'h1234, 1, 1);
    expect_cyc("desv_busca", 1, 16'h0001, 0, 16'hFFFF, 1, 16'h1234);
    chk("desv_busca.pc", pc, 16'h1234);
    drive(0, 1, 0, 16'h0000, 0, 0);
    expect_cyc("desv_ocioso", 0, 16'h0000, 0, 16'hFFFF, 0, 16'h1234);
    drive(0, 1, 0, 16'h0000, 0, 0);
    expect_cyc("desv_nova_busca", 1, 16'h1234, 0, 16'hFFFF, 0, 16'h1234);

    // Redirect to FFFF, then one fetch wraps the PC to 0000
    drive(0, 1, 1, 16'hFFFF, 0, 0);
    expect_cyc("desv_ffff", 1, 16'h1234, 0, 16'hFFFF, 1, 16'hFFFF);
    drive(0, 1, 0, 16'h0000, 1, 1);
    expect_cyc("wrap_ocioso", 0, 16'h0000, 0, 16'hFFFF, 0, 16'hFFFF);
    drive(0, 1, 0, 16'h0000, 1, 1);
    expect_cyc("wrap_busca", 1, 16'hFFFF, 0, 16'hFFFF, 1, 16'h0000);
    chk("wrap.pc", pc, 16'h0000);

    // Redirect in ENTREGA beats accept: word not delivered
    drive(0, 1, 1, 16'h0042, 1, 1);
    expect_cyc("desv_entrega", 0, 16'h0000, 1, 16'h0000, 1, 16'h0042);
    drive(0, 0, 0, 16'h0000, 1, 1);
    expect_cyc("pos_desv", 0, 16'h0000, 0, 16'h0000, 0, 16'h0042);
    drive(0, 0, 0, 16'h0000, 1, 1);
    expect_cyc("parado", 0, 16'h0000, 0, 16'h0000, 0, 16'h0042);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
